// File: rtl/ps2_key_decoder_if.sv
// rtl/ps2_key_decoder_if.sv - FIFO-side and decoded-key signal bundle for ps2_key_decoder
interface ps2_key_decoder_if #(
    parameter int NUM_KEYS = 3
);
    logic                fifo_empty;
    logic [7:0]          fifo_data;
    logic                fifo_rd;
    logic [7:0]          code_out;
    logic                code_ext;
    logic                code_break;
    logic                code_valid;
    logic [NUM_KEYS-1:0] key_held;
    logic [NUM_KEYS-1:0] key_pulse;

    modport master (
        input  fifo_empty, fifo_data,
        output fifo_rd, code_out, code_ext, code_break, code_valid, key_held, key_pulse
    );

    modport slave (
        output fifo_empty, fifo_data,
        input  fifo_rd, code_out, code_ext, code_break, code_valid, key_held, key_pulse
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 prefix resolver and per-key held/pulse tracker
// Optional auto-repeat counters are built when PS2_KEY_AUTOREPEAT_EN is defined.
module ps2_key_decoder #(
    parameter int                    NUM_KEYS      = 3,
    parameter logic [9*NUM_KEYS-1:0] KEY_CODES     = {9'h036, 9'h034, 9'h032},
    parameter int                    REPEAT_DELAY  = 12500000,
    parameter int                    REPEAT_PERIOD = 2500000
) (
    input  logic clk,
    input  logic rst,
    ps2_key_decoder_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] DEC  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic                rd_q, rd_d;
    logic [2:0]          skip_q, skip_d;
    logic                ext_q, ext_d;
    logic                brk_q, brk_d;
    logic [7:0]          code_q, code_d;
    logic                cext_q, cext_d;
    logic                cbrk_q, cbrk_d;
    logic                valid_q, valid_d;
    logic                done;
    logic [NUM_KEYS-1:0] match;
    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [NUM_KEYS-1:0] pulse_q, pulse_d;

    always_comb begin
        state_d = state_q;
        rd_d    = 1'b0;
        skip_d  = skip_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        code_d  = code_q;
        cext_d  = cext_q;
        cbrk_d  = cbrk_q;
        valid_d = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!bus.fifo_empty) begin
                    rd_d    = 1'b1;
                    state_d = RD;
                end
            end
            RD:  state_d = DEC;
            DEC: begin
                state_d = IDLE;
                // Pause (E1) is followed by 7 bytes that carry no key information
                if (skip_q != 3'd0) begin
                    skip_d = skip_q - 3'd1;
                end else if (bus.fifo_data == 8'hE1) begin
                    skip_d = 3'd7;
                end else if (bus.fifo_data == 8'hE0) begin
                    ext_d = 1'b1;
                end else if (bus.fifo_data == 8'hF0) begin
                    brk_d = 1'b1;
                end else begin
                    done    = 1'b1;
                    code_d  = bus.fifo_data;
                    cext_d  = ext_q;
                    cbrk_d  = brk_q;
                    valid_d = 1'b1;
                    ext_d   = 1'b0;
                    brk_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            match[i] = done && ({ext_q, bus.fifo_data} == KEY_CODES[9*i +: 9]);
        end
    end

`ifdef PS2_KEY_AUTOREPEAT_EN
    logic [23:0] cnt_q [NUM_KEYS];
    logic [23:0] cnt_d [NUM_KEYS];

    always_comb begin
        held_d  = held_q;
        pulse_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (match[i] && !brk_q && !held_q[i]) begin
                held_d[i]  = 1'b1;
                pulse_d[i] = 1'b1;
                cnt_d[i]   = 24'(REPEAT_DELAY);
            end else if (match[i] && brk_q) begin
                held_d[i] = 1'b0;
                cnt_d[i]  = 24'd0;
            end else if (held_q[i]) begin
                // typematic resends fall through here so the repeat cadence is undisturbed
                if (cnt_q[i] == 24'd1) begin
                    pulse_d[i] = 1'b1;
                    cnt_d[i]   = 24'(REPEAT_PERIOD);
                end else if (cnt_q[i] != 24'd0) begin
                    cnt_d[i] = cnt_q[i] - 24'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= 24'd0;
        end else begin
            for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= cnt_d[i];
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = ^{REPEAT_DELAY, REPEAT_PERIOD};

    always_comb begin
        held_d  = held_q;
        pulse_d = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (match[i] && !brk_q && !held_q[i]) begin
                held_d[i]  = 1'b1;
                pulse_d[i] = 1'b1;
            end else if (match[i] && brk_q) begin
                held_d[i] = 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            skip_q  <= 3'd0;
            ext_q   <= 1'b0;
            brk_q   <= 1'b0;
            code_q  <= 8'd0;
            cext_q  <= 1'b0;
            cbrk_q  <= 1'b0;
            valid_q <= 1'b0;
            held_q  <= '0;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            skip_q  <= skip_d;
            ext_q   <= ext_d;
            brk_q   <= brk_d;
            code_q  <= code_d;
            cext_q  <= cext_d;
            cbrk_q  <= cbrk_d;
            valid_q <= valid_d;
            held_q  <= held_d;
            pulse_q <= pulse_d;
        end
    end

    assign bus.fifo_rd    = rd_q;
    assign bus.code_out   = code_q;
    assign bus.code_ext   = cext_q;
    assign bus.code_break = cbrk_q;
    assign bus.code_valid = valid_q;
    assign bus.key_held   = held_q;
    assign bus.key_pulse  = pulse_q;
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - directed self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;
    localparam int NK = 3;
`ifdef PS2_KEY_AUTOREPEAT_EN
    localparam int RD_T = 20;
    localparam int RP_T = 5;
`else
    localparam int RD_T = 12500000;
    localparam int RP_T = 2500000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ps2_key_decoder_if #(.NUM_KEYS(NK)) dif ();

    ps2_key_decoder #(
        .NUM_KEYS(NK),
        .KEY_CODES({9'h036, 9'h034, 9'h032}),
        .REPEAT_DELAY(RD_T),
        .REPEAT_PERIOD(RP_T)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(dif)
    );

    logic [7:0] mem [0:63];
    logic [5:0] wr_ptr = 6'd0;
    logic [5:0] rd_ptr = 6'd0;
    logic [7:0] fdata  = 8'd0;
    assign dif.fifo_empty = (wr_ptr == rd_ptr);
    assign dif.fifo_data  = fdata;

    always @(posedge clk) begin
        if (dif.fifo_rd && (wr_ptr != rd_ptr)) begin
            fdata  <= mem[rd_ptr];
            rd_ptr <= rd_ptr + 6'd1;
        end
    end

    int nvec = 0;
    int nerr = 0;
    int cv_cnt, first_cv_cyc, dbl;
    int pc [NK];
    int pcyc [$];
    logic [7:0] last_code;
    logic last_ext, last_brk, first_ext, first_brk, prev_cv;
    logic [NK-1:0] prev_p, pulse_at_first_cv;

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic clr();
        cv_cnt = 0; first_cv_cyc = -1;
        last_code = 8'h00; last_ext = 1'b0; last_brk = 1'b0;
        first_ext = 1'b0; first_brk = 1'b0; pulse_at_first_cv = '0;
        for (int i = 0; i < NK; i++) pc[i] = 0;
        pcyc.delete();
    endtask

    task automatic run(input int n);
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            if (dif.code_valid) begin
                cv_cnt++;
                if (cv_cnt == 1) begin
                    first_cv_cyc = c;
                    first_ext = dif.code_ext;
                    first_brk = dif.code_break;
                    pulse_at_first_cv = dif.key_pulse;
                end
                last_code = dif.code_out;
                last_ext  = dif.code_ext;
                last_brk  = dif.code_break;
            end
            for (int i = 0; i < NK; i++) if (dif.key_pulse[i]) pc[i]++;
            if (dif.key_pulse[0]) pcyc.push_back(c);
            if (dif.code_valid && prev_cv) dbl++;
            if (|(dif.key_pulse & prev_p)) dbl++;
            prev_cv = dif.code_valid;
            prev_p  = dif.key_pulse;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        int exp_c [5];
        int obs_c;
        dbl = 0; prev_cv = 1'b0; prev_p = '0;
        clr();
        repeat (3) @(negedge clk);
        nvec++; if (dif.code_out !== 8'h00) begin nerr++; $error("FAIL rst_code_out observed=%0h expected=%0h", dif.code_out, 8'h00); end
        nvec++; if (dif.code_valid !== 1'b0) begin nerr++; $error("FAIL rst_code_valid observed=%0h expected=%0h", dif.code_valid, 1'b0); end
        nvec++; if (dif.code_ext !== 1'b0) begin nerr++; $error("FAIL rst_code_ext observed=%0h expected=%0h", dif.code_ext, 1'b0); end
        nvec++; if (dif.code_break !== 1'b0) begin nerr++; $error("FAIL rst_code_break observed=%0h expected=%0h", dif.code_break, 1'b0); end
        nvec++; if (dif.key_held !== 3'b000) begin nerr++; $error("FAIL rst_key_held observed=%0h expected=%0h", dif.key_held, 3'b000); end
        nvec++; if (dif.key_pulse !== 3'b000) begin nerr++; $error("FAIL rst_key_pulse observed=%0h expected=%0h", dif.key_pulse, 3'b000); end
        nvec++; if (dif.fifo_rd !== 1'b0) begin nerr++; $error("FAIL rst_fifo_rd observed=%0h expected=%0h", dif.fifo_rd, 1'b0); end
        rst = 1'b1;
        repeat (2) @(negedge clk);

        clr(); push(8'h34); run(6);
        nvec++; if (cv_cnt !== 1) begin nerr++; $error("FAIL make34_cv observed=%0h expected=%0h", cv_cnt, 1); end
        nvec++; if (first_cv_cyc !== 3) begin nerr++; $error("FAIL make34_latency observed=%0h expected=%0h", first_cv_cyc, 3); end
        nvec++; if (last_code !== 8'h34) begin nerr++; $error("FAIL make34_code observed=%0h expected=%0h", last_code, 8'h34); end
        nvec++; if (last_brk !== 1'b0) begin nerr++; $error("FAIL make34_brk observed=%0h expected=%0h", last_brk, 1'b0); end
        nvec++; if (dif.key_held !== 3'b010) begin nerr++; $error("FAIL make34_held observed=%0h expected=%0h", dif.key_held, 3'b010); end
        nvec++; if (pulse_at_first_cv !== 3'b010) begin nerr++; $error("FAIL make34_pulse_with_cv observed=%0h expected=%0h", pulse_at_first_cv, 3'b010); end
        nvec++; if (pc[1] !== 1) begin nerr++; $error("FAIL make34_pulse_cnt observed=%0h expected=%0h", pc[1], 1); end

        clr(); push(8'hF0); push(8'h34); run(10);
        nvec++; if (cv_cnt !== 1) begin nerr++; $error("FAIL brk34_cv observed=%0h expected=%0h", cv_cnt, 1); end
        nvec++; if (last_code !== 8'h34) begin nerr++; $error("FAIL brk34_code observed=%0h expected=%0h", last_code, 8'h34); end
        nvec++; if (last_brk !== 1'b1) begin nerr++; $error("FAIL brk34_brk observed=%0h expected=%0h", last_brk, 1'b1); end
        nvec++; if (dif.key_held !== 3'b000) begin nerr++; $error("FAIL brk34_held observed=%0h expected=%0h", dif.key_held, 3'b000); end
        nvec++; if (pc[1] !== 0) begin nerr++; $error("FAIL brk34_pulse_cnt observed=%0h expected=%0h", pc[1], 0); end

        clr(); push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75); run(20);
        nvec++; if (cv_cnt !== 2) begin nerr++; $error("FAIL e075_cv observed=%0h expected=%0h", cv_cnt, 2); end
        nvec++; if (first_ext !== 1'b1) begin nerr++; $error("FAIL e075_first_ext observed=%0h expected=%0h", first_ext, 1'b1); end
        nvec++; if (first_brk !== 1'b0) begin nerr++; $error("FAIL e075_first_brk observed=%0h expected=%0h", first_brk, 1'b0); end
        nvec++; if (last_ext !== 1'b1) begin nerr++; $error("FAIL e075_last_ext observed=%0h expected=%0h", last_ext, 1'b1); end
        nvec++; if (last_brk !== 1'b1) begin nerr++; $error("FAIL e075_last_brk observed=%0h expected=%0h", last_brk, 1'b1); end
        nvec++; if (last_code !== 8'h75) begin nerr++; $error("FAIL e075_code observed=%0h expected=%0h", last_code, 8'h75); end
        nvec++; if (dif.key_held !== 3'b000) begin nerr++; $error("FAIL e075_held observed=%0h expected=%0h", dif.key_held, 3'b000); end
        nvec++; if ((pc[0] + pc[1] + pc[2]) !== 0) begin nerr++; $error("FAIL e075_pulses observed=%0h expected=%0h", pc[0] + pc[1] + pc[2], 0); end

        clr(); push(8'h32); push(8'h32); push(8'h32); run(15);
        nvec++; if (cv_cnt !== 3) begin nerr++; $error("FAIL typ_cv observed=%0h expected=%0h", cv_cnt, 3); end
        nvec++; if (pc[0] !== 1) begin nerr++; $error("FAIL typ_pulse0 observed=%0h expected=%0h", pc[0], 1); end
        nvec++; if (dif.key_held !== 3'b001) begin nerr++; $error("FAIL typ_held observed=%0h expected=%0h", dif.key_held, 3'b001); end
        clr(); push(8'hF0); push(8'h32); run(10);
        nvec++; if (dif.key_held !== 3'b000) begin nerr++; $error("FAIL typ_release_held observed=%0h expected=%0h", dif.key_held, 3'b000); end

        clr();
        push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
        push(8'hF0); push(8'h14); push(8'hF0); push(8'h77); push(8'h36);
        run(40);
        nvec++; if (cv_cnt !== 1) begin nerr++; $error("FAIL pause_cv observed=%0h expected=%0h", cv_cnt, 1); end
        nvec++; if (first_cv_cyc !== 27) begin nerr++; $error("FAIL pause_cv_cycle observed=%0h expected=%0h", first_cv_cyc, 27); end
        nvec++; if (last_code !== 8'h36) begin nerr++; $error("FAIL pause_code observed=%0h expected=%0h", last_code, 8'h36); end
        nvec++; if (pc[2] !== 1) begin nerr++; $error("FAIL pause_pulse2 observed=%0h expected=%0h", pc[2], 1); end
        nvec++; if (dif.key_held !== 3'b100) begin nerr++; $error("FAIL pause_held observed=%0h expected=%0h", dif.key_held, 3'b100); end

        clr(); push(8'hE0); run(5);
        nvec++; if (cv_cnt !== 0) begin nerr++; $error("FAIL e0_only_cv observed=%0h expected=%0h", cv_cnt, 0); end
        push(8'h34);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (dif.fifo_rd) seen = 1'b1;
        end
        nvec++; if (seen !== 1'b1) begin nerr++; $error("FAIL rd_seen observed=%0h expected=%0h", seen, 1'b1); end
        rst = 1'b0;
        #1;
        nvec++; if (dif.code_out !== 8'h00) begin nerr++; $error("FAIL midrst_code_out observed=%0h expected=%0h", dif.code_out, 8'h00); end
        nvec++; if (dif.key_held !== 3'b000) begin nerr++; $error("FAIL midrst_held observed=%0h expected=%0h", dif.key_held, 3'b000); end
        nvec++; if (dif.fifo_rd !== 1'b0) begin nerr++; $error("FAIL midrst_fifo_rd observed=%0h expected=%0h", dif.fifo_rd, 1'b0); end
        @(negedge clk);
        rst = 1'b1;
        clr(); run(8);
        nvec++; if (cv_cnt !== 1) begin nerr++; $error("FAIL postrst_cv observed=%0h expected=%0h", cv_cnt, 1); end
        nvec++; if (last_code !== 8'h34) begin nerr++; $error("FAIL postrst_code observed=%0h expected=%0h", last_code, 8'h34); end
        nvec++; if (last_ext !== 1'b0) begin nerr++; $error("FAIL postrst_ext observed=%0h expected=%0h", last_ext, 1'b0); end
        nvec++; if (pc[1] !== 1) begin nerr++; $error("FAIL postrst_pulse1 observed=%0h expected=%0h", pc[1], 1); end
        clr(); push(8'hF0); push(8'h34); run(10);
        nvec++; if (dif.key_held !== 3'b000) begin nerr++; $error("FAIL postrst_release observed=%0h expected=%0h", dif.key_held, 3'b000); end

`ifdef PS2_KEY_AUTOREPEAT_EN
        exp_c = '{3, 23, 28, 33, 38};
        clr(); push(8'h32); run(39);
        nvec++; if (pc[0] !== 5) begin nerr++; $error("FAIL rep_count observed=%0h expected=%0h", pc[0], 5); end
        for (int k = 0; k < 5; k++) begin
            obs_c = (k < pcyc.size()) ? pcyc[k] : -1;
            nvec++; if (obs_c !== exp_c[k]) begin nerr++; $error("FAIL rep_cycle observed=%0h expected=%0h", obs_c, exp_c[k]); end
        end
        push(8'hF0); push(8'h32); run(7);
        clr(); run(30);
        nvec++; if (pc[0] !== 0) begin nerr++; $error("FAIL rep_after_break observed=%0h expected=%0h", pc[0], 0); end
        nvec++; if (dif.key_held !== 3'b000) begin nerr++; $error("FAIL rep_held_after_break observed=%0h expected=%0h", dif.key_held, 3'b000); end
`endif

        nvec++; if (dbl !== 0) begin nerr++; $error("FAIL no_double_strobe observed=%0h expected=%0h", dbl, 0); end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/ps2_key_decoder.md
Name: ps2_key_decoder

Overview:
- Parametrised PS/2 scan-code decoder, next generation of the top-level make/break prefix machine and the per-key pulse generators.
- Drains bytes from the ps2_if FIFO and resolves 0xE0/0xF0/0xE1 prefixes into complete codes.
- Tracks held state for NUM_KEYS programmable keys and emits one-cycle key pulses.
- Sits between ps2_if and TETRIS_GAME, replacing the inline decoder and the button_machine instances.

Parameters:
- NUM_KEYS, 3: number of tracked key channels, 1..16.
- KEY_CODES, {9'h036,9'h034,9'h032}: packed 9*NUM_KEYS bits. Key i is at [9i+8:9i]; bit 8 is the extended (E0) flag, bits 7:0 are the scan code.
- REPEAT_DELAY, 12500000: clocks from make to first auto-repeat pulse (AUTOREPEAT_EN only).
- REPEAT_PERIOD, 2500000: clocks between subsequent auto-repeat pulses (AUTOREPEAT_EN only).

Ports:
- clk  in  1  system clock, 25 MHz
- rst  in  1  asynchronous reset, active-low
- fifo_empty  in  1  ps2_if status[0]; 1 = no byte available
- fifo_data  in  8  ps2_if data[7:0]; valid the cycle after fifo_rd
- fifo_rd  out  1  one-cycle FIFO pop strobe
- code_out  out  8  last completed scan code
- code_ext  out  1  code_out was E0-prefixed
- code_break  out  1  code_out was F0-prefixed (release)
- code_valid  out  1  one-cycle strobe per completed code
- key_held  out  NUM_KEYS  level; 1 while key i is down
- key_pulse  out  NUM_KEYS  one-cycle strobe per key press or repeat

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, prefix flags and skip counter cleared, repeat counters 0. Reset mid-byte drops that byte; the FIFO is not re-read.
- FSM IDLE -> RD -> DEC -> IDLE.
- IDLE: if fifo_empty==0, drive fifo_rd<=1 and go to RD.
- RD: fifo_rd<=0, go to DEC.
- DEC: sample fifo_data, decode, go to IDLE.
- Throughput: at most one byte per 3 clocks. fifo_rd is never high for two consecutive cycles.
- Decode order in DEC:
  - If skip_cnt!=0: decrement and discard the byte.
  - Else 0xE1: skip_cnt<=7 (Pause sequence); no code emitted.
  - Else 0xE0: ext<=1.
  - Else 0xF0: brk<=1.
  - Else: the code is complete. code_out<=byte, code_ext<=ext, code_break<=brk, code_valid<=1 for one cycle. Then ext<=0, brk<=0.
- Registered outputs update on the clock edge that ends DEC. Latency is 3 clocks from fifo_empty falling in IDLE to code_valid.
- Key match: completed code with {ext,byte}==KEY_CODES[i].
  - Make with key_held[i]==0: key_held[i]<=1, key_pulse[i]<=1.
  - Make with key_held[i]==1 (typematic resend): no pulse.
  - Break: key_held[i]<=0, no pulse. A break for a key that is not held is ignored except for code_valid.
- Duplicate entries in KEY_CODES: all matching channels update.
- Prefix followed by prefix (E0 F0): both flags accumulate. A repeated E0 or F0 is idempotent.
- key_pulse and code_valid are never high for more than one consecutive cycle.

Optional Feature:
- Macro: PS2_KEY_AUTOREPEAT_EN.
- Defined:
  - Each channel has a 24-bit counter, loaded with REPEAT_DELAY on make and decremented while key_held[i]=1.
  - At 1 the counter pulses key_pulse[i] and reloads REPEAT_PERIOD. It clears on break.
  - A make-pulse and a repeat-pulse in the same cycle produce one pulse.
- Undefined: no counters are synthesised; pulses occur only on the make transition.

Test Plan:
- Bytes 0x34 then F0 34, default params -> code_valid twice with code_out=0x34 and code_break 0 then 1. key_held[1] goes 1 then 0. key_pulse[1] exactly one cycle after the first byte.
- Bytes E0 75 then E0 F0 75 -> code_ext=1 on both codes, code_break=0 then 1. key_held and key_pulse stay 0.
- Bytes 32 32 32 (typematic) -> three code_valid strobes, one key_pulse[0] strobe, key_held[0]=1.
- Bytes E1 14 77 E1 F0 14 F0 77 then 36 -> no code_valid for the first 8 bytes; code_out=0x36 and key_pulse[2] after the 9th.
- rst low during RD after E0 -> all outputs 0. The next 0x34 decodes with code_ext=0.
- With PS2_KEY_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5: make 0x32 held 40 clocks -> pulses at make, make+20, +25, +30, +35. Break stops the pulses.
